// File: rtl/conv1_pkg.sv
// conv1_pkg: shared sizes, FSM state type and ROM channel unpacking for the conv1 MAC engine.
package conv1_pkg;
    localparam int KS = 5;
    localparam int KK = KS * KS;
    localparam int OUT_CH = 6;
    localparam int W_WGT = 18;
    localparam int W_PIX = 8;
    localparam int W_ACC = 32;

    typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;

    // The ROM packs channel 0 in the most significant slice.
    function automatic logic [W_WGT-1:0] rom_ch(input logic [OUT_CH*W_WGT-1:0] qa, input int c);
        return qa[(OUT_CH-c)*W_WGT-1 -: W_WGT];
    endfunction
endpackage

// File: rtl/conv1_mac_lane.sv
// conv1_mac_lane: one output channel's multiply-accumulate across the kernel taps.
module conv1_mac_lane
    import conv1_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [W_PIX-1:0] pix,
    input  logic [W_WGT-1:0] wgt,
    input  logic             first,
    input  logic             en,
    output logic [W_ACC-1:0] acc
);
    localparam int W_PROD = W_PIX + W_WGT + 1;

    logic signed [W_PROD-1:0] prod;

    // Pixels are unsigned, so a zero sign bit keeps the product signed-correct.
    assign prod = $signed({1'b0, pix}) * $signed(wgt);

    always_ff @(posedge clk)
        if (!rstn)
            acc <= '0;
        else if (en)
            acc <= (first ? '0 : acc) + {{(W_ACC-W_PROD){prod[W_PROD-1]}}, prod};
endmodule

// File: rtl/conv1_mac_engine.sv
// conv1_mac_engine: walks the weight ROM over 25 taps of one pixel window and
// accumulates six channels in parallel, presenting one raw sum per window.
module conv1_mac_engine
    import conv1_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [KK*W_PIX-1:0]     win_data,
    output logic [11:0]             rom_aa,
    output logic                    rom_cena,
    input  logic [OUT_CH*W_WGT-1:0] rom_qa,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_CH*W_ACC-1:0] out_data
);
    localparam logic [4:0] LAST = 5'(KK - 1);
    localparam logic [4:0] PRE_LAST = 5'(KK - 2);

    state_t state;
    logic [4:0] tap;
    logic [KK*W_PIX-1:0] win;
    logic [W_PIX-1:0] pix;

    assign pix = win[tap*W_PIX +: W_PIX];

    always_ff @(posedge clk)
        if (!rstn) begin
            state <= IDLE;
            win_ready <= 1'b1;
            rom_aa <= '0;
            rom_cena <= 1'b1;
            out_valid <= 1'b0;
            tap <= '0;
            win <= '0;
        end else begin
            case (state)
                IDLE:
                    if (win_valid) begin
                        win <= win_data;
                        win_ready <= 1'b0;
                        rom_aa <= '0;
                        rom_cena <= 1'b0;
                        state <= FETCH;
                    end
                FETCH: begin
                    tap <= '0;
                    rom_aa <= 12'd1;
                    state <= MAC;
                end
                MAC: begin
                    // Address runs one tap ahead of the accumulation to cover ROM latency.
                    tap <= (tap == LAST) ? '0 : tap + 5'd1;
                    if (tap < PRE_LAST)
                        rom_aa <= 12'(tap + 5'd2);
                    if (tap == PRE_LAST)
                        rom_cena <= 1'b1;
                    if (tap == LAST) begin
                        out_valid <= 1'b1;
                        state <= OUT;
                    end
                end
                OUT:
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        win_ready <= 1'b1;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end

    // Lane accumulators hold their value outside MAC, so they double as the output register.
    for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
        conv1_mac_lane u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .pix   (pix),
            .wgt   (rom_ch(rom_qa, c)),
            .first (tap == '0),
            .en    (state == MAC),
            .acc   (out_data[c*W_ACC +: W_ACC])
        );
    end
endmodule

// File: tb/tb_conv1_mac_engine.sv
// tb_conv1_mac_engine: directed windows against a 1-cycle ROM model; a monitor
// process checks results, latency and the ROM address trace from a scoreboard queue.
module tb_conv1_mac_engine;
    import conv1_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic win_valid = 1'b0;
    logic win_ready;
    logic [KK*W_PIX-1:0] win_data = '0;
    logic [11:0] rom_aa;
    logic rom_cena;
    logic [OUT_CH*W_WGT-1:0] rom_qa = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [OUT_CH*W_ACC-1:0] out_data;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int mode = 0;
    logic [OUT_CH*W_ACC-1:0] exp_q[$];
    int acc_q[$];
    int cena_cnt = 0;
    int first_cena = 0;
    bit prev_ov = 1'b0;

    conv1_mac_engine dut (
        .clk       (clk),
        .rstn      (rstn),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .rom_aa    (rom_aa),
        .rom_cena  (rom_cena),
        .rom_qa    (rom_qa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: ch0 = t+1, ch1 = -(t+1); mode 1: every channel -131072 at tap 0 only
    function automatic logic [OUT_CH*W_WGT-1:0] rom_word(input int t);
        logic [OUT_CH*W_WGT-1:0] r = '0;
        logic [W_WGT-1:0] w;
        for (int c = 0; c < OUT_CH; c++) begin
            if (mode == 0)
                w = (c == 0) ? 18'(t + 1) : (c == 1) ? 18'(-(t + 1)) : '0;
            else
                w = (t == 0) ? 18'h20000 : '0;
            r[(OUT_CH-c)*W_WGT-1 -: W_WGT] = w;
        end
        return r;
    endfunction

    always @(posedge clk)
        if (!rom_cena) rom_qa <= rom_word(int'(rom_aa));

    task automatic chk(input bit ok, input string name, input logic [OUT_CH*W_ACC-1:0] act, input logic [OUT_CH*W_ACC-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // kind 0: all p; 1: tap0 = p; 2: pix[k] = k; 3: tap24 = p
    function automatic logic [KK*W_PIX-1:0] mk(input int kind, input int p);
        logic [KK*W_PIX-1:0] r = '0;
        for (int k = 0; k < KK; k++)
            r[k*W_PIX +: W_PIX] = (kind == 0) ? 8'(p) : (kind == 1 && k == 0) ? 8'(p) :
                                  (kind == 2) ? 8'(k) : (kind == 3 && k == KK-1) ? 8'(p) : 8'd0;
        return r;
    endfunction

    function automatic logic [OUT_CH*W_ACC-1:0] e2(input int v);
        logic [OUT_CH*W_ACC-1:0] r = '0;
        r[0 +: W_ACC] = 32'(v);
        r[W_ACC +: W_ACC] = 32'(-v);
        return r;
    endfunction

    function automatic logic [OUT_CH*W_ACC-1:0] e_all(input int v);
        logic [OUT_CH*W_ACC-1:0] r = '0;
        for (int c = 0; c < OUT_CH; c++) r[c*W_ACC +: W_ACC] = 32'(v);
        return r;
    endfunction

    task automatic send(input logic [KK*W_PIX-1:0] w, input logic [OUT_CH*W_ACC-1:0] e, output int t);
        int n = 0;
        win_data = w;
        win_valid = 1'b1;
        while (!win_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!win_ready) chk(1'b0, "accept_timeout", 0, 1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        t = cyc;
        win_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            acc_q.delete();
            cena_cnt = 0;
            prev_ov = 1'b0;
        end else begin
            if (win_valid && win_ready) begin
                acc_q.push_back(cyc);
                first_cena = cyc + 1;
            end
            if (!rom_cena) begin
                if (cena_cnt == 0) chk(cyc == first_cena, "cena_start", cyc, first_cena);
                chk(rom_aa == 12'(cena_cnt), "rom_aa", rom_aa, cena_cnt);
                cena_cnt++;
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() > 0) begin
                    chk(cyc - acc_q[0] == 27, "latency", cyc - acc_q[0], 27);
                    acc_q.pop_front();
                end else chk(1'b0, "latency_no_accept", 0, 27);
                chk(cena_cnt == KK, "cena_len", cena_cnt, KK);
                cena_cnt = 0;
            end
            if (out_valid && !out_ready) begin
                chk(exp_q.size() > 0 && out_data == exp_q[0], "stall_data", out_data, exp_q.size() > 0 ? exp_q[0] : '0);
                chk(!win_ready, "stall_win_ready", win_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    chk(out_data == exp_q[0], "result", out_data, exp_q[0]);
                    exp_q.pop_front();
                end else chk(1'b0, "unexpected_out", out_data, 0);
            end
            prev_ov = out_valid;
        end
    end

    task automatic check_reset_vals();
        @(negedge clk);
        chk(win_ready == 1'b1, "rst_win_ready", win_ready, 1);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(rom_cena == 1'b1, "rst_rom_cena", rom_cena, 1);
        chk(rom_aa == 12'd0, "rst_rom_aa", rom_aa, 0);
        chk(out_data == '0, "rst_out_data", out_data, 0);
    endtask

    initial begin
        int t, tp;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check_reset_vals();

        @(posedge clk); #1;
        send(mk(0, 1), e2(325), t);
        drain();

        mode = 1;
        send(mk(1, 255), e_all(-33423360), t);
        drain();
        mode = 0;

        // Stalled output with win_valid pulses that must be ignored
        out_ready = 1'b0;
        send(mk(2, 0), e2(5200), t);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = out_valid;
        end
        chk(ok, "stall_wait_valid", out_valid, 1);
        win_data = mk(0, 9);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            win_valid = i[0];
        end
        win_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset ten cycles after accept aborts the window
        send(mk(0, 2), e2(650), t);
        repeat (9) @(posedge clk);
        #1 rstn = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rstn = 1'b1;
        check_reset_vals();
        repeat (40) @(posedge clk);
        #1;
        send(mk(0, 2), e2(650), t);
        drain();

        // Back-to-back windows: accepts 28 cycles apart, no carry-over
        send(mk(0, 1), e2(325), tp);
        send(mk(3, 3), e2(75), t);
        chk(t - tp == 28, "b2b_period", t - tp, 28);
        tp = t;
        send(mk(2, 0), e2(5200), t);
        chk(t - tp == 28, "b2b_period", t - tp, 28);
        drain();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
